vga_timing_core: RTL and testbench

Parametrised VGA display controller: generates horizontal/vertical timing from a single system clock via an internal pixel-rate divider, prefetches pixels from an upstream frame buffer with a programmable lead, and drives registered sync, data-enable and colour outputs of configurable depth. It supersedes the fixed 640x480/1-bit core and sits between the frame buffer and the board VGA pins, reporting frame boundaries and pixel underflow.

---
 rtl/vga_timing_core.sv | 172 +++++++++++++++++
 tb/tb_vga_timing_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// VGA timing generator with pixel-rate divider, lead-time pixel prefetch and registered outputs.
// Optional VGA_TEST_PATTERN_EN adds i_self_test, which replaces frame-buffer pixels with 8 colour bars.
module vga_timing_core #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CW        = 1,
    parameter int CLK_DIV   = 2,
    parameter int FETCH_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          i_enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          i_self_test,
`endif
    input  logic [3*CW-1:0] i_pixel_rgb,
    input  logic          i_pixel_valid,
    output logic          o_h_sync,
    output logic          o_v_sync,
    output logic          o_de,
    output logic [CW-1:0] o_r,
    output logic [CW-1:0] o_g,
    output logic [CW-1:0] o_b,
    output logic          o_fetch_next_pixel,
    output logic          o_frame_start,
    output logic          o_underflow
);
    // state  | meaning
    // S_IDLE | disabled or in reset; counters parked at (0,0), outputs at reset levels
    // S_RUN  | raster running; every pixel tick enters the next position

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SB     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SB     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW:0]   H_TOT_X  = (HW+1)'(H_TOTAL);
    localparam logic [HW:0]   FLAT_X   = (HW+1)'(FETCH_LAT);
    localparam logic          H_ON     = 1'(H_POL);
    localparam logic          V_ON     = 1'(V_POL);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   div;
    logic [HW-1:0]   h, h_nxt, ha;
    logic [VW-1:0]   v, v_nxt, va;
    logic [HW:0]     h_sum;
    logic            pix_tick, enter, act_nxt, ahead_act, origin_nxt, self_test, uf_set;
    logic [3*CW-1:0] rgb_nxt;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    assign self_test = i_self_test;
    assign bar = 3'(({3'b000, h_nxt} << 3) / (HW+3)'(H_ACTIVE));
`else
    assign self_test = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pix_tick  = 1'b0;
        enter     = 1'b0;
        h_nxt     = h;
        v_nxt     = v;
        case (state)
            S_IDLE: begin
                if (i_enable) begin
                    state_nxt = S_RUN;
                    enter     = 1'b1;
                    h_nxt     = '0;
                    v_nxt     = '0;
                end
            end
            S_RUN: begin
                pix_tick = (div == DIV_LAST);
                if (!i_enable) begin
                    state_nxt = S_IDLE;
                end else if (pix_tick) begin
                    enter = 1'b1;
                    if (h == H_LAST) begin
                        h_nxt = '0;
                        v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
                    end else begin
                        h_nxt = h + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Look-ahead position; FETCH_LAT never exceeds H_BP, so one wrap is enough.
    always_comb begin
        h_sum = {1'b0, h_nxt} + FLAT_X;
        va    = v_nxt;
        if (h_sum >= H_TOT_X) begin
            ha = HW'(h_sum - H_TOT_X);
            va = (v_nxt == V_LAST) ? '0 : v_nxt + 1'b1;
        end else begin
            ha = h_sum[HW-1:0];
        end
        act_nxt    = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        ahead_act  = (ha < H_ACT) && (va < V_ACT);
        origin_nxt = (h_nxt == '0) && (v_nxt == '0);
        rgb_nxt    = '0;
        uf_set     = 1'b0;
        if (act_nxt) begin
`ifdef VGA_TEST_PATTERN_EN
            if (self_test)
                rgb_nxt = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
            else
`endif
            if (i_pixel_valid)
                rgb_nxt = i_pixel_rgb;
            else
                uf_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            div <= '0; h <= '0; v <= '0;
            o_h_sync <= ~H_ON; o_v_sync <= ~V_ON; o_de <= 1'b0;
            o_r <= '0; o_g <= '0; o_b <= '0;
            o_fetch_next_pixel <= 1'b0; o_frame_start <= 1'b0; o_underflow <= 1'b0;
        end else if (!i_enable) begin
            div <= '0; h <= '0; v <= '0;
            o_h_sync <= ~H_ON; o_v_sync <= ~V_ON; o_de <= 1'b0;
            o_r <= '0; o_g <= '0; o_b <= '0;
            o_fetch_next_pixel <= 1'b0; o_frame_start <= 1'b0; o_underflow <= 1'b0;
        end else begin
            div <= (state == S_RUN && !pix_tick) ? div + 1'b1 : '0;
            h   <= h_nxt;
            v   <= v_nxt;
            o_fetch_next_pixel <= enter && ahead_act && !self_test;
            o_frame_start      <= enter && origin_nxt;
            if (enter) begin
                o_h_sync <= (h_nxt >= H_SB && h_nxt < H_SE) ? H_ON : ~H_ON;
                o_v_sync <= (v_nxt >= V_SB && v_nxt < V_SE) ? V_ON : ~V_ON;
                o_de     <= act_nxt;
                {o_r, o_g, o_b} <= rgb_nxt;
                // A miss on the origin pixel itself must survive the per-frame clear.
                if (!self_test)
                    o_underflow <= (origin_nxt ? 1'b0 : o_underflow) | uf_set;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core on a small geometry: a clock-count raster model predicts every output each cycle.
module tb_vga_timing_core;
    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int H_POL = 0, V_POL = 0, CW = 2, CLK_DIV = 2, FETCH_LAT = 2;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic reset_, en, valid, self_test;
    logic [3*CW-1:0] rgb;
    logic h_sync, v_sync, de, fetch, fs, uf;
    logic [CW-1:0] r, g, b;

    always #5 clk = ~clk;

    vga_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL), .CW(CW), .CLK_DIV(CLK_DIV), .FETCH_LAT(FETCH_LAT)
    ) dut (
        .clk(clk), .reset_(reset_), .i_enable(en),
`ifdef VGA_TEST_PATTERN_EN
        .i_self_test(self_test),
`endif
        .i_pixel_rgb(rgb), .i_pixel_valid(valid),
        .o_h_sync(h_sync), .o_v_sync(v_sync), .o_de(de),
        .o_r(r), .o_g(g), .o_b(b),
        .o_fetch_next_pixel(fetch), .o_frame_start(fs), .o_underflow(uf)
    );

    int vectors = 0, miscompares = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k counts clks since the edge that entered (0,0); position = k / CLK_DIV.
    bit running, chk_on;
    int k;
    bit m_uf;
    logic e_hs, e_vs, e_de, e_fetch, e_fs;
    logic [3*CW-1:0] e_rgb;

    function automatic bit is_active(int p);
        return (p % HT) < H_ACTIVE && (p / HT) < V_ACTIVE;
    endfunction

    function automatic logic [3*CW-1:0] bar_rgb(int x);
        int bar;
        bar = x * 8 / H_ACTIVE;
        return {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
    endfunction

    task automatic model_reset();
        running = 0; k = 0; m_uf = 0;
        e_hs = !H_POL[0]; e_vs = !V_POL[0]; e_de = 0; e_rgb = '0; e_fetch = 0; e_fs = 0;
    endtask

    task automatic model_enter(int p);
        int x, y;
        bit act;
        x = p % HT; y = p / HT;
        act = is_active(p);
        e_hs = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? H_POL[0] : !H_POL[0];
        e_vs = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? V_POL[0] : !V_POL[0];
        e_de = act;
        e_fetch = is_active((p + FETCH_LAT) % FRAME) && !self_test;
        e_fs = (p == 0);
        e_rgb = '0;
        if (act) begin
            if (self_test) e_rgb = bar_rgb(x);
            else if (valid) e_rgb = rgb;
        end
        if (!self_test) m_uf = ((p == 0) ? 1'b0 : m_uf) | (act && !valid);
    endtask

    always @(posedge clk or negedge reset_) begin
        if (!reset_ || !en) model_reset();
        else if (!running) begin
            running = 1; k = 0; model_enter(0);
        end else begin
            k++;
            if (k % CLK_DIV == 0) model_enter((k / CLK_DIV) % FRAME);
            else begin e_fetch = 0; e_fs = 0; end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("h_sync", h_sync, e_hs);
            check("v_sync", v_sync, e_vs);
            check("de", de, e_de);
            check("rgb", {r, g, b}, e_rgb);
            check("fetch", fetch, e_fetch);
            check("frame_start", fs, e_fs);
            check("underflow", uf, m_uf);
        end
    end

    // Stimulus: mode 0 random pixels/valid, mode 1 pixel index with one dropout at (3,1).
    int mode = 0;

    function automatic int next_pos();
        if (!running) return 0;
        return (k / CLK_DIV + 1) % FRAME;
    endfunction

    task automatic drive();
        int p;
        if (mode == 0) begin
            valid = ($urandom_range(0, 9) != 0);
            rgb = (3*CW)'($urandom);
        end else begin
            p = next_pos();
            valid = (p != 3 + 1 * HT);
            rgb = is_active(p) ? (3*CW)'((p % HT) + (p / HT) * H_ACTIVE) : '0;
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            drive();
            @(negedge clk);
        end
    endtask

    initial begin
        int w, hs_low, vs_low, de_cnt, f_cnt, last_f, f252, uf_cnt, uf_rise, st_fetch;
        logic [3*CW-1:0] pix_5_2, pix_3_1;
        reset_ = 0; en = 0; valid = 0; rgb = '0; self_test = 0; chk_on = 0;
        repeat (3) @(negedge clk);
        check("rst_h_sync", h_sync, 1);
        check("rst_v_sync", v_sync, 1);
        check("rst_de", de, 0);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_fetch", fetch, 0);
        chk_on = 1;

        reset_ = 1; en = 1;
        step(1);
        check("first_frame_start", fs, 1);
        check("first_de", de, 1);
        step(600);

        mode = 1;
        w = 0;
        step(1);
        while (!fs && w < 600) begin step(1); w++; end
        check("frame_start_seen", fs, 1);
        hs_low = 0; vs_low = 0; de_cnt = 0; f_cnt = 0; last_f = -1; f252 = 0;
        uf_cnt = 0; uf_rise = -1; pix_5_2 = '0; pix_3_1 = '1;
        for (int off = 0; off < 2 * FRAME; off++) begin
            if (!h_sync) hs_low++;
            if (!v_sync) vs_low++;
            if (de) de_cnt++;
            if (fetch) begin f_cnt++; last_f = off; end
            if (off == 252) f252 = fetch;
            if (uf) begin uf_cnt++; if (uf_rise < 0) uf_rise = off; end
            if (off == 74) pix_5_2 = {r, g, b};
            if (off == 38) pix_3_1 = {r, g, b};
            step(1);
        end
        check("frame_period_256", fs, 1);
        check("underflow_cleared", uf, 0);
        check("h_sync_low_clks", hs_low, 48);
        check("v_sync_low_clks", vs_low, 64);
        check("de_clks", de_cnt, 64);
        check("fetch_pulses", f_cnt, 32);
        check("fetch_h14_last_line", f252, 1);
        check("last_fetch_off", last_f, 254);
        check("uf_rise_off", uf_rise, 38);
        check("uf_high_clks", uf_cnt, 218);
        check("pix_5_2", pix_5_2, 21);
        check("pix_3_1_dropped", pix_3_1, 0);

        mode = 0;
        w = 0;
        while (!(running && k % CLK_DIV == 0 && (k / CLK_DIV) % HT == 5) && w < 100) begin
            step(1); w++;
        end
        check("reached_h5", w < 100, 1);
        en = 0;
        step(1);
        check("dis_de", de, 0);
        check("dis_h_sync", h_sync, 1);
        check("dis_frame_start", fs, 0);
        step(3);
        en = 1;
        step(1);
        check("reen_frame_start", fs, 1);
        step(300);

        @(negedge clk);
        #2 reset_ = 0;
        #1;
        check("async_h_sync", h_sync, 1);
        check("async_v_sync", v_sync, 1);
        check("async_de", de, 0);
        check("async_rgb", {r, g, b}, 0);
        check("async_fetch", fetch, 0);
        @(negedge clk);
        @(negedge clk);
        reset_ = 1;
        step(1);
        check("rst_restart_fs", fs, 1);

`ifdef VGA_TEST_PATTERN_EN
        self_test = 1;
        st_fetch = 0;
        for (int i = 0; i < 300; i++) begin
            if (fetch && i > 0) st_fetch++;
            step(1);
        end
        check("selftest_fetch_pulses", st_fetch, 0);
        self_test = 0;
`else
        st_fetch = 0;
`endif
        step(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
